// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared types and helpers for the bit-serial subtractor.
//                Provides the controller state encoding and functions that
//                derive the digit count and the digit-counter width from the
//                operand width and the digit width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digits (clock cycles of processing) per operation.
    function automatic int calc_num_digits(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    // Digit counter width; a single-digit configuration still needs one bit.
    function automatic int calc_cnt_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_subtractor_16bit_sub_digit.sv
`default_nettype none
// ============================================================================
//  Module      : sub_digit
//  Description : Combinational ripple cell computing one digit of
//                a + ~b + carry_in. The caller seeds carry_in with ~borrow so
//                the cell performs subtraction; carry_out = ~borrow_out.
//  Ports       : digit_a    [BITS_PER_CYCLE-1:0] in  - minuend digit
//                digit_b    [BITS_PER_CYCLE-1:0] in  - subtrahend digit
//                carry_in                        in  - carry into the LSB
//                digit_diff [BITS_PER_CYCLE-1:0] out - difference digit
//                carry_out                       out - carry out of the MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_digit #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [BITS_PER_CYCLE-1:0] digit_a,
    input  logic [BITS_PER_CYCLE-1:0] digit_b,
    input  logic                      carry_in,
    output logic [BITS_PER_CYCLE-1:0] digit_diff,
    output logic                      carry_out
);

    logic w_carry;
    logic w_nb;

    // Ripple through the digit with a scalar carry variable so the chain
    // stays a simple combinational path rather than a self-referencing vector.
    always_comb begin
        digit_diff = '0;
        w_carry    = carry_in;
        w_nb       = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_nb          = ~digit_b[i];
            digit_diff[i] = digit_a[i] ^ w_nb ^ w_carry;
            w_carry       = (digit_a[i] & w_nb) | (w_carry & (digit_a[i] ^ w_nb));
        end
        carry_out = w_carry;
    end

endmodule : sub_digit
`default_nettype wire

// File: rtl/serial_subtractor_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_16bit
//  Description : Multi-cycle digit-serial two's-complement subtractor.
//                Computes diff = a - b - bin, LSB digit first, with
//                BITS_PER_CYCLE bits per clock, using a start/busy/done
//                handshake. Results are registered and held until the next
//                completion.
//  Ports       : clk       in  - rising-edge clock
//                rst_n     in  - asynchronous active-low reset
//                start     in  - request, sampled in IDLE or DONE
//                a         in  [WIDTH-1:0] minuend
//                b         in  [WIDTH-1:0] subtrahend
//                bin       in  - borrow-in
//                busy      out - digits being processed
//                done      out - one-cycle result-valid pulse
//                diff      out [WIDTH-1:0] a - b - bin mod 2^WIDTH
//                bout      out - borrow-out (unsigned a < b + bin)
//                overflow  out - signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_16bit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int c_num_digits = calc_num_digits(WIDTH, BITS_PER_CYCLE);
    localparam int c_cnt_w      = calc_cnt_width(c_num_digits);
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(c_num_digits - 1);

    // Reject digit widths that do not tile the operand exactly.
    if ((BITS_PER_CYCLE < 1) || (BITS_PER_CYCLE > WIDTH) ||
        ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_bits_per_cycle
        $error("serial_subtractor_16bit: BITS_PER_CYCLE must divide WIDTH");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               state_q,   state_d;
    logic [c_cnt_w-1:0]   cnt_q,     cnt_d;
    // The minuend register doubles as the result register: each processed
    // digit of a leaves at the bottom while the matching difference digit
    // enters at the top, so after the last digit it holds the full result.
    logic [WIDTH-1:0]     a_sh_q,    a_sh_d;
    logic [WIDTH-1:0]     b_sh_q,    b_sh_d;
    logic                 carry_q,   carry_d;
    logic                 a_msb_q,   a_msb_d;
    logic                 b_msb_q,   b_msb_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [WIDTH-1:0]     diff_q,    diff_d;
    logic                 bout_q,    bout_d;
    logic                 ovf_q,     ovf_d;

    logic [BITS_PER_CYCLE-1:0] w_digit_diff;
    logic                      w_carry_out;
    logic [WIDTH-1:0]          w_a_next;

    sub_digit #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_sub_digit (
        .digit_a    (a_sh_q[BITS_PER_CYCLE-1:0]),
        .digit_b    (b_sh_q[BITS_PER_CYCLE-1:0]),
        .carry_in   (carry_q),
        .digit_diff (w_digit_diff),
        .carry_out  (w_carry_out)
    );

    if (BITS_PER_CYCLE < WIDTH) begin : g_shift_multi
        assign w_a_next = {w_digit_diff, a_sh_q[WIDTH-1:BITS_PER_CYCLE]};
    end else begin : g_shift_single
        assign w_a_next = w_digit_diff;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = ~bin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = w_a_next;
                b_sh_d  = b_sh_q >> BITS_PER_CYCLE;
                carry_d = w_carry_out;
                cnt_d   = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_last_digit) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    diff_d  = w_a_next;
                    bout_d  = ~w_carry_out;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (w_a_next[WIDTH-1] ^ a_msb_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered versions of the next state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign bout     = bout_q;
    assign overflow = ovf_q;

endmodule : serial_subtractor_16bit
`default_nettype wire
